shift_sub_divider: RTL
======================

# shift_sub_divider

Iterative restoring (shift-and-subtract) unsigned divider. It is the inverse datapath of the shift-and-add multiplier and uses the same `in_valid` / `stall` / `out_valid` handshake, so two copies can be dropped into a miter with contract shadow logic. Data-dependent latency is confined to a single compile-time feature, so the constant-time and leaky variants can be checked against each other.

## Interface
- `WIDTH`, default 4: operand width; power of two, ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request strobe; sampled only in IDLE with `stall`=0.
- `stall`  in  1  freezes all state when high.
- `a`  in  WIDTH  dividend.
- `b`  in  WIDTH  divisor.
- `q`  out  WIDTH  quotient, registered.
- `r`  out  WIDTH  remainder, registered.
- `out_valid`  out  1  result valid; high only in DONE.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
- States: IDLE, CALC, DONE.
- Working registers:
  - `rem` (WIDTH bits)
  - `quo` (WIDTH bits, initially the dividend, shifted left)
  - `dvs` (WIDTH bits)
  - `cnt` (log2(WIDTH)+1 bits)
  - result registers `q` and `r`
- IDLE with `in_valid`=1 and `stall`=0: load `quo`←`a`, `dvs`←`b`, `rem`←0, `cnt`←0, then go to CALC (see Configuration for the early-exit branch). `in_valid` in any other state is ignored; there is no queueing.
- CALC, each unstalled cycle:
  - `t` = {`rem`, `quo`[WIDTH-1]} (WIDTH+1 bits).
  - If `t` ≥ `dvs`: `rem`←`t`−`dvs` and shift 1 into `quo`[0].
  - Otherwise: `rem`←`t`[WIDTH-1:0] and shift 0 into `quo`[0].
  - `cnt`←`cnt`+1.
  - When the incremented `cnt` equals WIDTH, go to DONE and load `q`←final quotient, `r`←final remainder.
- DONE: `out_valid`=1 for one unstalled cycle, then return to IDLE. A new request is not accepted in the DONE cycle.
- Divide by zero produces `q` = all ones and `r` = `a`. This falls out of the algorithm and is not a special case.
- `q` and `r` hold their value from DONE until the next result is loaded. They never expose working registers.
- `stall`=1 freezes the state, working registers, `q`, `r` and `out_valid`. A result in DONE therefore stays visible for as long as `stall` is held.

## Timing
- Reset values: state IDLE, `q`=0, `r`=0, `out_valid`=0, `busy`=0, all working registers 0.
- If the request is accepted at edge k:
  - `busy`=1 from cycle k+1.
  - Full-length operation is in CALC for cycles k+1..k+WIDTH and in DONE at cycle k+WIDTH+1 (`out_valid` high).
  - IDLE again at cycle k+WIDTH+2.
  - Each stalled cycle adds exactly one cycle of latency.
- Reset asserted mid-operation aborts immediately: no `out_valid`, results cleared to 0.
- Deasserting `rst_n` and asserting `in_valid` together: the request is accepted at the first rising edge after release.
- `stall` and `in_valid` together in IDLE: the request is not taken.

## Configuration
- `DIV_EARLY_EXIT_EN` defined:
  - On accept, if `b`=0, go directly to DONE with `q`=all ones, `r`=`a`.
  - On accept, if `a` < `b` (including `a`=0), go directly to DONE with `q`=0, `r`=`a`.
  - In both cases `out_valid` is high at cycle k+1.
  - Results are identical to the full computation; only latency differs. This is the timing-leaky variant.
- `DIV_EARLY_EXIT_EN` undefined: every operation takes exactly WIDTH CALC cycles, so latency is independent of the operands.

## Test plan
- WIDTH=4, `a`=13, `b`=4, accepted at edge k → `out_valid` at k+5 for one cycle, `q`=3, `r`=1, then `busy`=0.
- `a`=5, `b`=0 → `q`=15, `r`=5. With the macro, at k+1; without it, at k+5.
- `a`=2, `b`=7 → `q`=0, `r`=2. With the macro, `out_valid` at k+1; without it, at k+5.
- `a`=15, `b`=1 with `stall` high for 2 cycles during CALC → `out_valid` at k+7, `q`=15, `r`=0. Holding `stall` while in DONE keeps `out_valid` high.
- `in_valid` pulsed with new operands (`a`=9, `b`=3) during CALC and during DONE → ignored. The first result is unchanged and no second `out_valid` occurs.
- `rst_n` low at cycle k+2 of a full-length operation → `out_valid`=0, `q`=`r`=0, IDLE. The next request completes normally.

Source files
------------

// File: rtl/shift_sub_divider.sv
// Iterative restoring (shift-and-subtract) unsigned divider with in_valid/stall/out_valid handshake.
// Optional macro DIV_EARLY_EXIT_EN enables the operand-dependent early exit (timing-leaky variant).
module shift_sub_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             out_valid,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q_q, res_q_d;
  logic [WIDTH-1:0] res_r_q, res_r_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_sub;
  logic             fits;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // Partial remainder stays below the divisor, so the difference always fits in WIDTH bits.
  always_comb begin
    trial    = {rem_q, quo_q[WIDTH-1]};
    fits     = (trial >= {1'b0, dvs_q});
    rem_sub  = trial[WIDTH-1:0] - dvs_q;
    rem_next = fits ? rem_sub : trial[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], fits};
    cnt_inc  = cnt_q + CW'(1);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    res_q_d = res_q_q;
    res_r_d = res_r_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          quo_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_EARLY_EXIT_EN
          if (b == '0) begin
            res_q_d = '1;
            res_r_d = a;
            state_d = DONE;
          end else if (a < b) begin
            res_q_d = '0;
            res_r_d = a;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_inc;
        if (cnt_inc == CW'(WIDTH)) begin
          res_q_d = quo_next;
          res_r_d = rem_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      res_q_q <= '0;
      res_r_q <= '0;
    end else if (!stall) begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      res_q_q <= res_q_d;
      res_r_q <= res_r_d;
    end
  end

  assign q         = res_q_q;
  assign r         = res_r_q;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule
